// File: rtl/full_tap_seq_if.sv
// Tap-sequencer bus: host load port, stage tap stream and write-back.
// The master side is the host/stage; the slave side is the sequencer.
interface full_tap_seq_if #(
    parameter int LANES  = 6,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
);
    logic                     start;
    logic                     mode;
    logic                     load_valid;
    logic [ADDR_W-1:0]        load_addr;
    logic [LANES*WIDTH-1:0]   load_data;
    logic                     in_valid;
    logic [LANES*WIDTH-1:0]   tap_in;
    logic [LANES*WIDTH-1:0]   taps;
    logic                     first;
    logic                     stage_error_mode;
    logic                     stage_error_first;
    logic                     busy;
    logic                     done;

    modport master (
        output start, mode, load_valid, load_addr, load_data,
        output in_valid, tap_in,
        input  taps, first, stage_error_mode, stage_error_first,
        input  busy, done
    );

    modport slave (
        input  start, mode, load_valid, load_addr, load_data,
        input  in_valid, tap_in,
        output taps, first, stage_error_mode, stage_error_first,
        output busy, done
    );
endinterface

// File: rtl/full_tap_seq.sv
// Tap store and row sequencer for one fully connected stage.
// Streams DEPTH rows per pass; update passes write stage rows back.
module full_tap_seq #(
    parameter int LANES  = 6,
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    full_tap_seq_if.slave bus
);
    localparam int RW = LANES * WIDTH;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_e;

    state_e            state_q, state_d;
    logic              pass_mode_q, pass_mode_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wr_full_q, wr_full_d;
    logic [RW-1:0]     taps_q, taps_d;
    logic              first_q, first_d;
    logic              err_mode_q, err_mode_d;
    logic              err_first_q, err_first_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [RW-1:0]     mem [DEPTH];

    logic              start_ok;
    logic              ld_en;
    logic              issue;
    logic              wb_en;
    logic              wr_last;
    logic [ADDR_W-1:0] rd_addr;
    logic [RW-1:0]     rd_row;

    // Row 0 is issued on the start edge, so a same-cycle load is bypassed
    always_comb begin
        start_ok = (state_q == IDLE) && bus.start;
        ld_en    = (state_q == IDLE) && bus.load_valid;
        issue    = start_ok || (state_q == STREAM);
        rd_addr  = start_ok ? '0 : rd_ptr_q;
        rd_row   = mem[rd_addr];
        if (ld_en && (bus.load_addr == rd_addr)) begin
            rd_row = bus.load_data;
        end
        wb_en    = bus.in_valid && !wr_full_q &&
                   ((start_ok && bus.mode) ||
                    (pass_mode_q &&
                     ((state_q == STREAM) || (state_q == DRAIN))));
        wr_last  = wb_en && (wr_ptr_q == LAST);
    end

    always_comb begin
        state_d     = state_q;
        pass_mode_d = pass_mode_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        wr_full_d   = wr_full_q;
        taps_d      = taps_q;
        if (issue) begin
            taps_d   = rd_row;
            rd_ptr_d = rd_addr + ADDR_W'(1);
        end
        if (wb_en) begin
            if (wr_last) wr_full_d = 1'b1;
            else         wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = STREAM;
                    pass_mode_d = bus.mode;
                end
            end
            STREAM: begin
                if (rd_ptr_q == LAST) begin
                    if (pass_mode_q && !(wr_full_q || wr_last))
                        state_d = DRAIN;
                    else
                        state_d = FIN;
                end
            end
            DRAIN: begin
                if (wr_last) state_d = FIN;
            end
            FIN: begin
                state_d   = IDLE;
                wr_ptr_d  = '0;
                wr_full_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        first_d     = start_ok;
        err_first_d = start_ok && bus.mode;
        err_mode_d  = pass_mode_d &&
                      ((state_d == STREAM) || (state_d == DRAIN));
        busy_d      = (state_d != IDLE);
        done_d      = (state_q == FIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pass_mode_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            wr_full_q   <= 1'b0;
            taps_q      <= '0;
            first_q     <= 1'b0;
            err_mode_q  <= 1'b0;
            err_first_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_mode_q <= pass_mode_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_full_q   <= wr_full_d;
            taps_q      <= taps_d;
            first_q     <= first_d;
            err_mode_q  <= err_mode_d;
            err_first_q <= err_first_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Store survives reset; a write-back after a load in one cycle wins
    always_ff @(posedge clk) begin
        if (ld_en) mem[bus.load_addr] <= bus.load_data;
        if (wb_en) mem[wr_ptr_q] <= bus.tap_in;
    end

    assign bus.taps              = taps_q;
    assign bus.first             = first_q;
    assign bus.stage_error_mode  = err_mode_q;
    assign bus.stage_error_first = err_first_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
endmodule

// File: tb/tb_full_tap_seq.sv
// Randomized bench for full_tap_seq against a row-store reference model.
// Cycle 0 of a pass is the cycle in which start is driven high.
module tb_full_tap_seq;
    localparam int NC = 64;

    logic clk = 1'b0;
    logic reset;

    full_tap_seq_if #(.LANES(6), .WIDTH(32), .ADDR_W(4)) bus ();

    full_tap_seq #(
        .LANES(6), .WIDTH(32), .DEPTH(16), .ADDR_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [191:0] mdl [16];
    bit           iv_pat [NC];
    bit           st_pat [NC];
    bit           ld_pat [NC];
    logic [191:0] wb_pat [NC];
    logic [3:0]   ld_addr;
    logic [191:0] ld_data;

    task automatic chk(input string tag, input logic [191:0] got,
                       input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [191:0] pat_row(input int r);
        logic [191:0] v;
        for (int k = 0; k < 6; k++)
            v[32*k +: 32] = 32'h3F80_0000 + 32'(16 * r + k);
        return v;
    endfunction

    function automatic logic [191:0] rnd_row();
        logic [191:0] v;
        for (int k = 0; k < 6; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.mode       = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        bus.in_valid   = 1'b0;
        bus.tap_in     = '0;
    endtask

    task automatic clear_pats();
        for (int c = 0; c < NC; c++) begin
            iv_pat[c] = 1'b0;
            st_pat[c] = 1'b0;
            ld_pat[c] = 1'b0;
            wb_pat[c] = '0;
        end
    endtask

    task automatic load_row(input int r, input logic [191:0] d);
        bus.load_valid = 1'b1;
        bus.load_addr  = 4'(r);
        bus.load_data  = d;
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        mdl[r] = d;
    endtask

    // One pass: rows read in cycle r come back on taps in cycle r+1;
    // the j-th accepted write-back lands in row j.
    task automatic run_pass(input bit m, input string nm);
        logic [191:0] rd_val [16];
        int cnt, c16, fin, nwr, ri;
        cnt = 0; c16 = -1; nwr = 0; fin = 16;
        for (int r = 0; r < 16; r++) rd_val[r] = '0;
        if (m) begin
            for (int c = 0; c < NC; c++)
                if (iv_pat[c] && c16 < 0) begin
                    cnt++;
                    if (cnt == 16) c16 = c;
                end
            if (c16 + 1 > fin) fin = c16 + 1;
        end
        for (int c = 0; c <= fin + 2; c++) begin
            bus.start      = (c == 0) || st_pat[c];
            bus.mode       = m;
            bus.in_valid   = iv_pat[c];
            bus.tap_in     = wb_pat[c];
            bus.load_valid = ld_pat[c];
            bus.load_addr  = ld_addr;
            bus.load_data  = ld_data;
            @(negedge clk);
            if (c >= 1) begin
                ri = (c <= 16) ? c - 1 : 15;
                chk($sformatf("%s taps c%0d", nm, c), bus.taps, rd_val[ri]);
                chk($sformatf("%s first c%0d", nm, c),
                    192'(bus.first), 192'(c == 1));
                chk($sformatf("%s err_first c%0d", nm, c),
                    192'(bus.stage_error_first), 192'(c == 1 && m));
                chk($sformatf("%s err_mode c%0d", nm, c),
                    192'(bus.stage_error_mode), 192'(m && c < fin));
                chk($sformatf("%s busy c%0d", nm, c),
                    192'(bus.busy), 192'(c <= fin));
                chk($sformatf("%s done c%0d", nm, c),
                    192'(bus.done), 192'(c == fin + 1));
            end
            if (c < 16) rd_val[c] = mdl[c];
            if (m && iv_pat[c] && nwr < 16 && c < fin) begin
                mdl[nwr] = wb_pat[c];
                nwr++;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        clear_pats();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        clear_pats();
        ld_addr = '0;
        ld_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset taps", bus.taps, '0);
        chk("reset busy", 192'(bus.busy), 192'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle taps", bus.taps, '0);
        chk("idle busy", 192'(bus.busy), 192'(0));
        chk("idle done", 192'(bus.done), 192'(0));
        chk("idle err_mode", 192'(bus.stage_error_mode), 192'(0));
        @(posedge clk); #1;

        for (int r = 0; r < 16; r++) load_row(r, pat_row(r));
        run_pass(1'b0, "fwd1");

        for (int c = 3; c < 19; c++) begin
            iv_pat[c] = 1'b1;
            wb_pat[c] = {6{32'h4000_0000}};
        end
        run_pass(1'b1, "upd2");
        run_pass(1'b0, "fwd2");

        for (int r = 0; r < 16; r++) load_row(r, rnd_row());
        for (int c = 0; c < 16; c++) begin
            iv_pat[c] = 1'b1;
            wb_pat[c] = rnd_row();
        end
        run_pass(1'b1, "upd3");
        run_pass(1'b0, "fwd3");

        st_pat[3] = 1'b1;
        st_pat[9] = 1'b1;
        ld_pat[5] = 1'b1;
        ld_addr   = 4'd5;
        ld_data   = rnd_row();
        run_pass(1'b0, "busy4");
        run_pass(1'b0, "fwd4");

        for (int r = 0; r < 16; r++) load_row(r, pat_row(r));
        for (int c = 0; c < 8; c++) begin
            bus.start    = (c == 0);
            bus.mode     = 1'b1;
            bus.in_valid = (c < 7);
            bus.tap_in   = rnd_row();
            if (c < 7) mdl[c] = bus.tap_in;
            @(negedge clk);
            if (c == 7) begin
                chk("rst5 busy before", 192'(bus.busy), 192'(1));
                chk("rst5 err_mode before",
                    192'(bus.stage_error_mode), 192'(1));
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        chk("rst5 taps", bus.taps, '0);
        chk("rst5 busy", 192'(bus.busy), 192'(0));
        chk("rst5 first", 192'(bus.first), 192'(0));
        chk("rst5 err_mode", 192'(bus.stage_error_mode), 192'(0));
        chk("rst5 err_first", 192'(bus.stage_error_first), 192'(0));
        chk("rst5 done", 192'(bus.done), 192'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run_pass(1'b0, "fwd5");

        for (int c = 3; c < 23; c++) begin
            iv_pat[c] = 1'b1;
            wb_pat[c] = rnd_row();
        end
        run_pass(1'b1, "upd6");
        run_pass(1'b0, "fwd6");

        for (int c = 0; c < NC; c++) begin
            iv_pat[c] = (c >= 40) || ($urandom_range(2) != 0);
            wb_pat[c] = rnd_row();
        end
        run_pass(1'b1, "updR");
        run_pass(1'b0, "fwdR");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/full_tap_seq.md
Name: full_tap_seq

Overview:
- Tap store and sequencer on the other side of a fully connected stage's tap interface.
- Holds DEPTH rows of LANES float_24_8 taps, and streams one row per cycle into the stage's `taps` input, with `first` and the error-mode strobes aligned to the row stream.
- In update passes it also accepts the stage's registered `tap_out` rows and writes them back into the store.
- Sits between the host/loader and each full stage instance.

Parameters:
- LANES, 6, neurons per stage (tap lanes per row).
- WIDTH, 32, bits per tap (float_24_8).
- DEPTH, 16, rows (inputs per neuron); a power of two.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-low reset; 0 = reset.
- start  input  1  one-cycle pulse that begins a pass; sampled only in IDLE.
- mode  input  1  pass type: 0 = forward, 1 = update; sampled with start.
- load_valid  input  1  host write strobe.
- load_addr  input  ADDR_W  host write row.
- load_data  input  LANES*WIDTH  host write row data; lane k at [32k+31:32k].
- in_valid  input  1  tap_in row valid (stage tap_out qualifier).
- tap_in  input  LANES*WIDTH  updated tap row from the stage.
- taps  output  LANES*WIDTH  registered tap row to the stage.
- first  output  1  high with row 0 of every pass.
- stage_error_mode  output  1  high for the whole of an update pass.
- stage_error_first  output  1  equals first AND update pass.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at pass completion.

Behaviour:
- Reset (reset = 0, asynchronous):
  - taps = 0; first, stage_error_mode, stage_error_first, busy and done = 0.
  - FSM goes to IDLE; read and write pointers = 0.
  - Store array is not reset; contents are retained across reset, including reset mid-pass.
- States: IDLE, STREAM, DRAIN, FIN.
- IDLE:
  - load_valid writes load_data to row load_addr.
  - start = 1: latch mode into pass_mode, rd_ptr = 0, wr_ptr = 0, go to STREAM.
  - load_valid and start in the same cycle: the load completes first; STREAM reads the new data.
- STREAM:
  - Each cycle, taps <= row[rd_ptr], rd_ptr++.
  - first = 1 on the cycle taps carries row 0; row 0 appears one cycle after the start cycle.
  - Leaves STREAM when rd_ptr = DEPTH-1 has been issued.
  - pass_mode = 0: go to FIN. pass_mode = 1: go to DRAIN.
- Update pass, write-back:
  - From the start cycle until FIN, each in_valid = 1 writes tap_in into row[wr_ptr], then wr_ptr++.
  - Write-backs are accepted in STREAM and DRAIN alike.
  - DRAIN exits to FIN after the DEPTH-th write.
  - in_valid is ignored in forward passes and in IDLE.
  - Writes beyond DEPTH within a pass are dropped; wr_ptr does not wrap within a pass.
- Read/write same row, same cycle: the read returns the old contents (read-before-write).
- FIN: done = 1 for exactly one cycle, then IDLE. busy drops in the same cycle done rises.
- Error-mode strobes:
  - stage_error_mode is registered and follows pass_mode from the first output row through the last write-back; 0 otherwise.
  - stage_error_first = first & pass_mode.
- Ignored inputs:
  - start while busy is ignored.
  - load_valid while busy is ignored; the store is protected during passes.
- Latency:
  - Forward pass: start to done = DEPTH+1 cycles.
  - Update pass: done = 1 cycle after the later of the last row issued and the DEPTH-th write.
- taps holds its last row after STREAM; only the row bus updates are qualified by STREAM.
- Pointers are ADDR_W bits; rd_ptr wraps DEPTH-1 -> 0 only on a state exit.

Test Plan:
1. Reset release, IDLE: taps = 0, busy = 0, done = 0.
   - Load rows 0..15 with lane k = 32'h3F80_0000 + 16*row + k.
   - Forward start: first high with row 0, taps row 15 on cycle 16, done on cycle 17, stage_error_mode = 0 throughout.
2. Update pass, in_valid fed 2 cycles after each row with tap_in = 32'h4000_0000 in all lanes:
   - stage_error_first pulses with row 0 and done follows the 16th write.
   - A following forward pass reads 32'h4000_0000 in every lane.
3. Update pass with in_valid aligned to the read pointer (same row, same cycle): streamed taps show the old values; the stored rows are the new ones.
4. start pulsed on cycles 3 and 9 of a pass, plus load_valid to row 5 mid-pass: no restart, row 5 unchanged, exactly one done.
5. reset = 0 asserted mid-update after 7 writes: outputs 0 immediately (asynchronous); after release a forward pass shows rows 0..6 updated and rows 7..15 original.
6. 20 in_valid pulses in one update pass: only rows 0..15 written, no wrap onto row 0, done after the 16th write.
